// File: rtl/booth_seq_mul.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock over a widened
// accumulator, with valid/ready handshakes on the operand and product sides.
module booth_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out,
  output logic                       busy,
  output logic [WIDTH-1:0]           step_acc,
  output logic [WIDTH-1:0]           step_q,
  output logic                       step_q0,
  output logic [$clog2(WIDTH):0]     step_cnt
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a source holds valid and its data stable until that edge.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     m;
  logic [WIDTH-1:0]   q;
  logic               q0;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] out_r;
  logic               out_valid_r;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     nxt_acc;
  logic [WIDTH-1:0]   nxt_q;
  logic               nxt_q0;
  logic               last_step;

  // Accumulator carries one extra sign bit so A-M cannot overflow for M = -2^(WIDTH-1).
  always_comb begin
    sum = acc;
    case ({q[0], q0})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign nxt_acc   = {sum[WIDTH], sum[WIDTH:1]};
  assign nxt_q     = {sum[0], q[WIDTH-1:1]};
  assign nxt_q0    = q[0];
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      m           <= '0;
      q           <= '0;
      q0          <= 1'b0;
      cnt         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            q     <= a;
            q0    <= 1'b0;
            m     <= {b[WIDTH-1], b};
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= nxt_acc;
          q   <= nxt_q;
          q0  <= nxt_q0;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            out_r       <= {nxt_acc[WIDTH-1:0], nxt_q};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so the engine never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign step_acc  = acc[WIDTH-1:0];
  assign step_q    = q;
  assign step_q0   = q0;
  assign step_cnt  = cnt;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Bench for booth_seq_mul: directed corner products, backpressure, reset abort
// and a randomized run, all scored against signed a*b.
module tb_booth_seq_mul;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out;
  logic           busy;
  logic [W-1:0]   step_acc;
  logic [W-1:0]   step_q;
  logic           step_q0;
  logic [CW-1:0]  step_cnt;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  bit rnd_ready   = 1'b0;
  bit fixed_ready = 1'b1;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy),
    .step_acc  (step_acc),
    .step_q    (step_q),
    .step_q0   (step_q0),
    .step_cnt  (step_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit push);
    int n;
    int p;
    logic [2*W-1:0] e;
    n = 0;
    @(posedge clk);
    #1;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose for a=0x%0h b=0x%0h", aa, bb);
    end else if (push) begin
      p = int'($signed(aa)) * int'($signed(bb));
      e = p[2*W-1:0];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  logic [2*W-1:0] prev_out;
  bit             prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_out", out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_product: got 0x%0h expected no product", out);
        end else begin
          chk("product", out, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  initial begin
    int lat;
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] corner[4];
    corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'h00; corner[3] = 8'hFF;

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_acc", step_acc, 0);
    chk("rst_step_q", step_q, 0);
    chk("rst_step_q0", step_q0, 0);
    chk("rst_step_cnt", step_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // 100 * -8: first step debug state and latency
    send(8'd100, 8'hF8, 1'b1);
    @(posedge clk);
    #1;
    chk("s1_acc", step_acc, 8'h00);
    chk("s1_q", step_q, 8'h32);
    chk("s1_q0", step_q0, 0);
    chk("s1_cnt", step_cnt, 1);
    chk("s1_busy", busy, 1);
    chk("s1_in_ready", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, W);
    wait_drain();

    // corner operands
    send(8'h80, 8'h80, 1'b1); wait_drain();
    send(8'h80, 8'h7F, 1'b1); wait_drain();
    send(8'h00, 8'hFF, 1'b1); wait_drain();
    send(8'hFF, 8'hFF, 1'b1); wait_drain();
    send(8'h7F, 8'h7F, 1'b1); wait_drain();

    // backpressure with an ignored in_valid pulse
    fixed_ready = 1'b0;
    @(posedge clk);
    send(8'd25, 8'hFD, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        a = 8'd3;
        b = 8'd3;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    in_valid = 1'b0;
    fixed_ready = 1'b1;
    wait_drain();
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_valid_low", out_valid, 0);
    chk("bp_out_kept", out, 16'hFFB5);

    // reset abort after step 4, then a clean product
    send(8'd100, 8'hF8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("ab_cnt", step_cnt, 4);
    rst_n = 1'b0;
    #1;
    chk("ab_in_ready", in_ready, 0);
    chk("ab_out_valid", out_valid, 0);
    chk("ab_out", out, 0);
    chk("ab_busy", busy, 0);
    chk("ab_step_acc", step_acc, 0);
    chk("ab_step_q", step_q, 0);
    chk("ab_step_q0", step_q0, 0);
    chk("ab_step_cnt", step_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd5, 8'hF9, 1'b1);
    wait_drain();
    chk("ab_out_after", out, 16'hFFDD);

    // randomized regression
    rnd_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(ra, rb, 1'b1);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
